parity_check: RTL and testbench

Receive-side companion to the `parity` even-parity generator. Accepts a 6-bit codeword `{parity, data[4:0]}`, checks it serially one bit per clock, then reports the recovered data, a parity-error flag and a one-cycle `done` strobe. It also keeps a saturating count of bad codewords for status readout. It sits at the consuming end of the link that the `parity` block drives.

---
 rtl/parity_check.sv | 151 +++++++++++++++
 tb/tb_parity_check.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_check.sv
// ---------------------------------------------------------------------------
// parity_check
//   Receive-side checker for the even-parity link. It accepts a codeword
//   {parity_bit, data}, folds it one bit per clock into a running XOR, and
//   then reports the recovered payload, a parity-error flag and a one-cycle
//   done strobe. It also keeps a saturating count of bad codewords.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for start; codeword is latched on the accepting edge
//   SHIFT | folding one codeword bit per clock into the accumulator
//   DONE  | one-cycle result strobe; start here chains the next codeword
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   codeword   : {parity_bit, data}, sampled only on the accepting edge
//   start      : request to check codeword (ignored while busy)
//   busy       : high while shifting
//   done       : one-cycle strobe, result valid
//   data_out   : recovered payload, held until the next done
//   parity_err : odd parity seen, held until the next done
//   err_cnt    : saturating count of bad codewords
// ---------------------------------------------------------------------------
module parity_check #(
    parameter int DATA_W    = 5,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W:0]      codeword,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    data_out,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [DATA_W:0]      sreg_q, sreg_d;
    logic [DATA_W-1:0]    payload_q, payload_d;
    logic                 acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic                 parity_err_q, parity_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 final_par;

    // Parity including the bit being consumed this cycle; on the last
    // SHIFT edge that bit is the transmitted parity bit.
    assign final_par = acc_q ^ sreg_q[0];

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        payload_d    = payload_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        err_cnt_d    = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sreg_d    = codeword;
                    payload_d = codeword[DATA_W-1:0];
                    acc_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d  = final_par;
                sreg_d = sreg_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    parity_err_d = final_par;
                    data_out_d   = payload_q;
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                    if (final_par && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                done_d = 1'b0;
                if (start) begin
                    sreg_d    = codeword;
                    payload_d = codeword[DATA_W-1:0];
                    acc_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy is registered from the next state so it stays a flop output.
        busy_d = (state_d == S_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sreg_q       <= '0;
            payload_q    <= '0;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            payload_q    <= payload_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            data_out_q   <= data_out_d;
            parity_err_q <= parity_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = data_out_q;
    assign parity_err = parity_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_parity_check.sv
// ---------------------------------------------------------------------------
// tb_parity_check
//   Directed bench for parity_check: a table of codewords with hand-computed
//   payload and parity-error results, plus hand-written sequences for reset
//   abort, back-to-back operation, start during SHIFT and counter saturation.
// ---------------------------------------------------------------------------
module tb_parity_check;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] codeword;
    logic       start;
    logic       busy;
    logic       done;
    logic [4:0] data_out;
    logic       parity_err;
    logic [3:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [5:0] cw;
        logic [4:0] d;
        logic       e;
        string      name;
    } vec_t;

    vec_t tab [5];

    parity_check #(.DATA_W(5), .ERR_CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .codeword   (codeword),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .parity_err (parity_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges stepped until done was seen (20 = timeout).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!done && cyc < 20);
    endtask

    task automatic send_check(input vec_t v);
        int cyc;
        codeword = v.cw;
        start    = 1'b1;
        step();
        start    = 1'b0;
        codeword = ~v.cw;
        check({v.name, "_busy"}, int'(busy), 1);
        wait_done(cyc);
        if (v.e && exp_cnt < 15) exp_cnt++;
        check({v.name, "_latency"}, cyc, 6);
        check({v.name, "_data"}, int'(data_out), int'(v.d));
        check({v.name, "_perr"}, int'(parity_err), int'(v.e));
        check({v.name, "_errcnt"}, int'(err_cnt), exp_cnt);
        step();
        check({v.name, "_done_fall"}, int'(done), 0);
    endtask

    initial begin
        int cyc;
        int seen;

        tab[0] = '{cw: 6'h21, d: 5'h01, e: 1'b0, name: "good_21"};
        tab[1] = '{cw: 6'h17, d: 5'h17, e: 1'b0, name: "good_17"};
        tab[2] = '{cw: 6'h2e, d: 5'h0e, e: 1'b0, name: "good_2e"};
        tab[3] = '{cw: 6'h20, d: 5'h00, e: 1'b1, name: "bad_20"};
        tab[4] = '{cw: 6'h3f, d: 5'h1f, e: 1'b0, name: "good_3f"};

        rst      = 1'b1;
        start    = 1'b0;
        codeword = 6'h00;
        step();
        step();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_perr", int'(parity_err), 0);
        check("rst_errcnt", int'(err_cnt), 0);
        rst     = 1'b0;
        exp_cnt = 0;
        step();

        for (int i = 0; i < 5; i++) begin
            send_check(tab[i]);
            step();
            step();
        end

        // Reset in the middle of a check: no done, everything cleared.
        codeword = 6'h21;
        start    = 1'b1;
        step();                 // E0
        start    = 1'b0;
        step();                 // E1
        step();                 // E2
        rst = 1'b1;
        step();                 // E3
        rst = 1'b0;
        exp_cnt = 0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_data", int'(data_out), 0);
        check("abort_perr", int'(parity_err), 0);
        check("abort_errcnt", int'(err_cnt), 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_idle", int'(busy), 0);

        // Back-to-back: start held during the DONE cycle.
        codeword = 6'h17;
        start    = 1'b1;
        step();
        start    = 1'b0;
        wait_done(cyc);
        check("b2b_first_latency", cyc, 6);
        check("b2b_first_data", int'(data_out), 5'h17);
        codeword = 6'h01;
        start    = 1'b1;
        step();
        start    = 1'b0;
        codeword = 6'h3e;
        check("b2b_done_fall", int'(done), 0);
        check("b2b_busy", int'(busy), 1);
        wait_done(cyc);
        exp_cnt = 1;
        check("b2b_spacing", cyc + 1, 7);
        check("b2b_data", int'(data_out), 5'h01);
        check("b2b_perr", int'(parity_err), 1);
        check("b2b_errcnt", int'(err_cnt), exp_cnt);
        step();
        step();

        // start pulsed during SHIFT must be ignored.
        codeword = 6'h2e;
        start    = 1'b1;
        step();                 // E0
        start    = 1'b0;
        step();                 // E1
        codeword = 6'h00;
        start    = 1'b1;
        step();                 // E2
        start    = 1'b0;
        wait_done(cyc);
        check("mid_latency", cyc + 2, 6);
        check("mid_data", int'(data_out), 5'h0e);
        check("mid_perr", int'(parity_err), 0);
        check("mid_errcnt", int'(err_cnt), exp_cnt);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) seen++;
        end
        check("mid_no_second_done", seen, 0);

        // Saturation: 17 bad words, counter stops at 15.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        step();
        for (int i = 0; i < 17; i++) begin
            send_check('{cw: 6'h01, d: 5'h01, e: 1'b1, name: $sformatf("sat_%0d", i)});
        end
        check("sat_final", int'(err_cnt), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
